// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file geometry and helpers used by the writeback arbiter,
// the 8x16 register file and the decoder.
package regfile_write_arbiter_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // Next index in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from an internal
// pointer that moves just past the winner whenever a grant is taken.
module rr_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant_idx;
    logic             found;
    int               idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= PTR_W'(wrap_inc(int'(grant_idx), NUM_REQ));
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources and
// tracks pending writes per register so issue can stall on RAW hazards.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = regfile_write_arbiter_pkg::DATA_W,
    parameter int ADDR_W  = regfile_write_arbiter_pkg::ADDR_W,
    parameter int CNT_W   = 2
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        Req_valid,
    output logic [NUM_REQ-1:0]        Req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] Req_address,
    input  logic [NUM_REQ*DATA_W-1:0] Req_data,
    output logic                      Reg_Write,
    output logic [ADDR_W-1:0]         Reg_input_address,
    output logic [DATA_W-1:0]         Reg_input_data,
    input  logic                      Issue_valid,
    input  logic [ADDR_W-1:0]         Issue_address,
    output logic                      Issue_ready,
    input  logic [ADDR_W-1:0]         Query_address1,
    input  logic [ADDR_W-1:0]         Query_address2,
    input  logic [ADDR_W-1:0]         Query_address3,
    output logic                      Busy1,
    output logic                      Busy2,
    output logic                      Busy3,
    output logic                      Sb_error
);

    import regfile_write_arbiter_pkg::*;

    localparam int NUM_ENTRIES = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_REQ-1:0]     grant;
    logic                   handshake;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_data;
    logic [CNT_W-1:0]       pend_cnt [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] inc_vec;
    logic [NUM_ENTRIES-1:0] dec_vec;
    logic                   issue_fire;
    logic                   commit_same;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arbiter (
        .clk    (CLK),
        .rst    (Reset),
        .req    (Req_valid),
        .advance(handshake),
        .grant  (grant)
    );

    assign Req_ready = grant;
    assign handshake = |(Req_valid & grant);

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = Req_address[i*ADDR_W +: ADDR_W];
                sel_data = Req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Address and data hold their last values when no write is launched.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            Reg_Write         <= 1'b0;
            Reg_input_address <= '0;
            Reg_input_data    <= '0;
        end else begin
            Reg_Write <= handshake;
            if (handshake) begin
                Reg_input_address <= sel_addr;
                Reg_input_data    <= sel_data;
            end
        end
    end

    // A commit to the issuing register frees a slot this very edge.
    assign commit_same = Reg_Write && (Reg_input_address == Issue_address);
    assign Issue_ready = (pend_cnt[Issue_address] != CNT_MAX) || commit_same;
    assign issue_fire  = Issue_valid && Issue_ready;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 0; r < NUM_ENTRIES; r++) begin
            inc_vec[r] = issue_fire && (Issue_address == ADDR_W'(r));
            dec_vec[r] = Reg_Write && (Reg_input_address == ADDR_W'(r));
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int r = 0; r < NUM_ENTRIES; r++) begin
                pend_cnt[r] <= '0;
            end
            Sb_error <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_ENTRIES; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    pend_cnt[r] <= pend_cnt[r] + CNT_W'(1);
                end else if (dec_vec[r] && !inc_vec[r] && (pend_cnt[r] != '0)) begin
                    pend_cnt[r] <= pend_cnt[r] - CNT_W'(1);
                end
            end
            if (Reg_Write && (pend_cnt[Reg_input_address] == '0)) begin
                Sb_error <= 1'b1;
            end
        end
    end

    assign Busy1 = (pend_cnt[Query_address1] != '0);
    assign Busy2 = (pend_cnt[Query_address2] != '0);
    assign Busy3 = (pend_cnt[Query_address3] != '0);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: arbitration, output timing,
// scoreboard saturation/commit interplay, sticky error and async reset.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_address;
    logic [31:0] req_data;
    logic        reg_write;
    logic [2:0]  reg_input_address;
    logic [15:0] reg_input_data;
    logic        issue_valid;
    logic [2:0]  issue_address;
    logic        issue_ready;
    logic [2:0]  query_address1;
    logic [2:0]  query_address2;
    logic [2:0]  query_address3;
    logic        busy1;
    logic        busy2;
    logic        busy3;
    logic        sb_error;

    int check_count = 0;
    int error_count = 0;

    regfile_write_arbiter #(
        .NUM_REQ(2),
        .DATA_W (16),
        .ADDR_W (3),
        .CNT_W  (2)
    ) dut (
        .CLK              (clk),
        .Reset            (reset),
        .Req_valid        (req_valid),
        .Req_ready        (req_ready),
        .Req_address      (req_address),
        .Req_data         (req_data),
        .Reg_Write        (reg_write),
        .Reg_input_address(reg_input_address),
        .Reg_input_data   (reg_input_data),
        .Issue_valid      (issue_valid),
        .Issue_address    (issue_address),
        .Issue_ready      (issue_ready),
        .Query_address1   (query_address1),
        .Query_address2   (query_address2),
        .Query_address3   (query_address3),
        .Busy1            (busy1),
        .Busy2            (busy2),
        .Busy3            (busy3),
        .Sb_error         (sb_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] valid,
                                  input logic [2:0] a0, input logic [15:0] d0,
                                  input logic [2:0] a1, input logic [15:0] d1,
                                  input logic iv, input logic [2:0] ia);
        req_valid     = valid;
        req_address   = {a1, a0};
        req_data      = {d1, d0};
        issue_valid   = iv;
        issue_address = ia;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b0, 3'd0);
        query_address1 = 3'd0;
        query_address2 = 3'd0;
        query_address3 = 3'd0;
        #150;
        reset = 1'b0;
        #1;
        check_output("rst_reg_write", 32'(reg_write), 32'd0);
        check_output("rst_busy", 32'({busy1, busy2, busy3}), 32'd0);
        check_output("rst_issue_ready", 32'(issue_ready), 32'd1);
        check_output("rst_sb_error", 32'(sb_error), 32'd0);
        check_output("rst_req_ready", 32'(req_ready), 32'd0);

        // Pre-issue r2 and r3 twice each so the contention writes are expected.
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b1, 3'd2);
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b1, 3'd2);
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b1, 3'd3);
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b1, 3'd3);
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b0, 3'd0);
        query_address2 = 3'd2;
        query_address3 = 3'd3;
        sample();
        check_output("pre_busy2", 32'(busy2), 32'd1);
        check_output("pre_busy3", 32'(busy3), 32'd1);

        // Contention: grants alternate 0,1,0,1; writes trail by one cycle.
        for (int k = 0; k < 4; k++) begin
            step();
            apply_stimulus(2'b11, 3'd2, 16'hAAAA, 3'd3, 16'h5555, 1'b0, 3'd0);
            sample();
            check_output($sformatf("cont_ready_%0d", k), 32'(req_ready),
                         (k % 2 == 0) ? 32'd1 : 32'd2);
            if (k > 0) begin
                check_output($sformatf("cont_we_%0d", k), 32'(reg_write), 32'd1);
                check_output($sformatf("cont_addr_%0d", k), 32'(reg_input_address),
                             (k % 2 == 1) ? 32'd2 : 32'd3);
                check_output($sformatf("cont_data_%0d", k), 32'(reg_input_data),
                             (k % 2 == 1) ? 32'hAAAA : 32'h5555);
            end
        end
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b0, 3'd0);
        sample();
        check_output("cont_last_we", 32'(reg_write), 32'd1);
        check_output("cont_last_addr", 32'(reg_input_address), 32'd3);
        check_output("cont_last_data", 32'(reg_input_data), 32'h5555);
        check_output("cont_busy2_clear", 32'(busy2), 32'd0);
        check_output("cont_busy3_pending", 32'(busy3), 32'd1);
        step(); sample();
        check_output("cont_idle_we", 32'(reg_write), 32'd0);
        check_output("cont_busy3_clear", 32'(busy3), 32'd0);
        check_output("cont_sb_error", 32'(sb_error), 32'd0);

        // Single write to r1 after issuing it.
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b1, 3'd1);
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b0, 3'd0);
        query_address1 = 3'd1;
        sample();
        check_output("single_busy_issue", 32'(busy1), 32'd1);
        step(); apply_stimulus(2'b01, 3'd1, 16'h1234, 3'd0, 16'h0, 1'b0, 3'd0);
        sample();
        check_output("single_ready", 32'(req_ready), 32'd1);
        check_output("single_we_early", 32'(reg_write), 32'd0);
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b0, 3'd0);
        sample();
        check_output("single_we", 32'(reg_write), 32'd1);
        check_output("single_addr", 32'(reg_input_address), 32'd1);
        check_output("single_data", 32'(reg_input_data), 32'h1234);
        check_output("single_ready_idle", 32'(req_ready), 32'd0);
        check_output("single_busy_commit", 32'(busy1), 32'd1);
        step(); sample();
        check_output("single_we_off", 32'(reg_write), 32'd0);
        check_output("single_addr_hold", 32'(reg_input_address), 32'd1);
        check_output("single_data_hold", 32'(reg_input_data), 32'h1234);
        check_output("single_busy_clear", 32'(busy1), 32'd0);

        // r4: fill to saturation, then drain with three commits.
        query_address1 = 3'd4;
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b1, 3'd4);
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b1, 3'd4);
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b1, 3'd4);
        sample();
        check_output("r4_busy_cnt2", 32'(busy1), 32'd1);
        check_output("r4_ready_cnt2", 32'(issue_ready), 32'd1);
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b1, 3'd4);
        sample();
        check_output("r4_ready_full", 32'(issue_ready), 32'd0);
        step(); apply_stimulus(2'b01, 3'd4, 16'h0401, 3'd0, 16'h0, 1'b0, 3'd4);
        sample();
        check_output("r4_ready_full_nocommit", 32'(issue_ready), 32'd0);
        step(); apply_stimulus(2'b01, 3'd4, 16'h0402, 3'd0, 16'h0, 1'b0, 3'd4);
        sample();
        check_output("r4_commit1_data", 32'(reg_input_data), 32'h0401);
        check_output("r4_ready_full_commit", 32'(issue_ready), 32'd1);
        step(); apply_stimulus(2'b01, 3'd4, 16'h0403, 3'd0, 16'h0, 1'b0, 3'd4);
        sample();
        check_output("r4_busy_c2", 32'(busy1), 32'd1);
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b0, 3'd4);
        sample();
        check_output("r4_commit3_data", 32'(reg_input_data), 32'h0403);
        check_output("r4_busy_c3", 32'(busy1), 32'd1);
        step(); sample();
        check_output("r4_busy_clear", 32'(busy1), 32'd0);
        check_output("r4_we_off", 32'(reg_write), 32'd0);

        // r5: issue and commit on the same edge leave the count at 1.
        query_address2 = 3'd5;
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b1, 3'd5);
        step(); apply_stimulus(2'b10, 3'd0, 16'h0, 3'd5, 16'h5005, 1'b0, 3'd5);
        sample();
        check_output("r5_ready_req1", 32'(req_ready), 32'd2);
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b1, 3'd5);
        sample();
        check_output("r5_we", 32'(reg_write), 32'd1);
        check_output("r5_addr", 32'(reg_input_address), 32'd5);
        check_output("r5_issue_ready", 32'(issue_ready), 32'd1);
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b0, 3'd0);
        sample();
        check_output("r5_busy_same_edge", 32'(busy2), 32'd1);
        step(); apply_stimulus(2'b01, 3'd5, 16'h5006, 3'd0, 16'h0, 1'b0, 3'd0);
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b0, 3'd0);
        sample();
        check_output("r5_data2", 32'(reg_input_data), 32'h5006);
        step(); sample();
        check_output("r5_busy_clear", 32'(busy2), 32'd0);
        check_output("r5_sb_error", 32'(sb_error), 32'd0);

        // r6: commit with nothing pending raises the sticky error.
        query_address3 = 3'd6;
        step(); apply_stimulus(2'b01, 3'd6, 16'h6666, 3'd0, 16'h0, 1'b0, 3'd0);
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b0, 3'd0);
        sample();
        check_output("r6_we", 32'(reg_write), 32'd1);
        check_output("r6_err_before", 32'(sb_error), 32'd0);
        step(); sample();
        check_output("r6_err_set", 32'(sb_error), 32'd1);
        check_output("r6_no_underflow", 32'(busy3), 32'd0);
        step(); step(); sample();
        check_output("r6_err_sticky", 32'(sb_error), 32'd1);
        check_output("r6_busy_still0", 32'(busy3), 32'd0);

        // Async reset mid-cycle while a write pulse is on the port.
        query_address3 = 3'd7;
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b1, 3'd7);
        step(); apply_stimulus(2'b01, 3'd7, 16'h7777, 3'd0, 16'h0, 1'b0, 3'd0);
        sample();
        check_output("mid_busy3", 32'(busy3), 32'd1);
        step(); apply_stimulus(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b0, 3'd0);
        sample();
        check_output("mid_we_before", 32'(reg_write), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_output("mid_we_dropped", 32'(reg_write), 32'd0);
        check_output("mid_addr_cleared", 32'(reg_input_address), 32'd0);
        check_output("mid_data_cleared", 32'(reg_input_data), 32'd0);
        check_output("mid_busy_cleared", 32'({busy1, busy2, busy3}), 32'd0);
        check_output("mid_sb_error_cleared", 32'(sb_error), 32'd0);
        #10;
        reset = 1'b0;
        step(); sample();
        check_output("post_rst_we", 32'(reg_write), 32'd0);
        check_output("post_rst_issue_ready", 32'(issue_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
